gru_seq_ctrl: RTL

Sequencer that runs the fixed-latency, fully parallel GRU cell datapath over an input sequence of `seq_len` timesteps. It accepts one `x_t` vector per step over a valid/ready handshake and holds the cell inputs stable for the cell's pipeline latency. It feeds each `h_t` back as the next `h_t_minus_1` and presents the final hidden state on an output handshake. It sits between the input-frame buffer and the downstream dense/classifier layer, and it owns the recurrent state register.

---
 rtl/gru_seq_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/gru_seq_ctrl.sv
// Sequencer for a fixed-latency GRU cell: feeds x_t and the recurrent h register, waits out the cell, presents h.
// Optional GRU_SEQ_EMIT_ALL_EN: present h_out after every step instead of only after the final one.
module gru_seq_ctrl #(
    parameter int WIDTH        = 16,
    parameter int x_SIZE       = 8,
    parameter int h_SIZE       = 8,
    parameter int CELL_LATENCY = 6,
    parameter int CNT_W        = 7
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_seq_len,
    input  logic             i_x_valid,
    output logic             o_x_ready,
    input  logic [WIDTH-1:0] i_x_in        [x_SIZE],
    output logic             o_cell_start,
    output logic [WIDTH-1:0] o_cell_x_t    [x_SIZE],
    output logic [WIDTH-1:0] o_cell_h_prev [h_SIZE],
    input  logic [WIDTH-1:0] i_cell_h_t    [h_SIZE],
    output logic [WIDTH-1:0] o_h_out       [h_SIZE],
    output logic             o_h_out_valid,
    input  logic             i_h_out_ready,
    output logic             o_busy,
    output logic             o_done
);

    localparam int WAIT_W = (CELL_LATENCY > 1) ? $clog2(CELL_LATENCY) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_CAPT,
        S_OUT
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_seq_len;
    logic [CNT_W-1:0]   r_step_cnt;
    logic [CNT_W-1:0]   w_step_inc;
    logic               w_last_step;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic               r_cell_start;
    logic [WIDTH-1:0]   r_x [x_SIZE];
    logic [WIDTH-1:0]   r_h [h_SIZE];

    assign w_step_inc  = r_step_cnt + 1'b1;
    assign w_last_step = (r_step_cnt == r_seq_len);

    assign o_cell_start  = r_cell_start;
    assign o_cell_x_t    = r_x;
    assign o_cell_h_prev = r_h;
    assign o_h_out       = r_h;

    // The wait counter is loaded as x is accepted, so RUN lasts exactly CELL_LATENCY cycles.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_seq_len    <= '0;
            r_step_cnt   <= '0;
            r_wait_cnt   <= '0;
            r_cell_start <= 1'b0;
            for (int i = 0; i < x_SIZE; i++) r_x[i] <= '0;
            for (int i = 0; i < h_SIZE; i++) r_h[i] <= '0;
        end else begin
            r_state      <= w_next_state;
            r_cell_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_seq_len  <= i_seq_len;
                        r_step_cnt <= '0;
                        for (int i = 0; i < h_SIZE; i++) r_h[i] <= '0;
                    end
                end
                S_LOAD: begin
                    if (i_x_valid) begin
                        r_x          <= i_x_in;
                        r_wait_cnt   <= WAIT_W'(CELL_LATENCY - 1);
                        r_cell_start <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (r_wait_cnt != '0) r_wait_cnt <= r_wait_cnt - 1'b1;
                end
                S_CAPT: begin
                    r_h        <= i_cell_h_t;
                    r_step_cnt <= w_step_inc;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next_state  = r_state;
        o_x_ready     = 1'b0;
        o_h_out_valid = 1'b0;
        o_busy        = 1'b1;
        o_done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) w_next_state = (i_seq_len == '0) ? S_OUT : S_LOAD;
            end
            S_LOAD: begin
                o_x_ready = 1'b1;
                if (i_x_valid) w_next_state = S_RUN;
            end
            S_RUN: begin
                if (r_wait_cnt == '0) w_next_state = S_CAPT;
            end
            S_CAPT: begin
`ifdef GRU_SEQ_EMIT_ALL_EN
                w_next_state = S_OUT;
`else
                w_next_state = (w_step_inc == r_seq_len) ? S_OUT : S_LOAD;
`endif
            end
            S_OUT: begin
                o_h_out_valid = 1'b1;
                // Outside emit-all mode OUT is only reached on the final step, so this always ends the sequence.
                if (i_h_out_ready) begin
                    o_done       = w_last_step;
                    w_next_state = w_last_step ? S_IDLE : S_LOAD;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

endmodule
